// File: rtl/pixel_proc_pipe.sv
// Pipelined VGA pixel-processing stage: colour op (bypass/gray/invert/threshold/brightness),
// frame-boundary config shadowing, and matched delay of sync and visible counters.
module pixel_proc_pipe #(
    parameter int unsigned CH_W        = 4,
    parameter int unsigned CNT_W       = 11,
    parameter int unsigned EXTRA_DELAY = 0,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic [CNT_W-1:0]   hc_visible_in,
    input  logic [CNT_W-1:0]   vc_visible_in,
    input  logic [3*CH_W-1:0]  pixel_in,
    input  logic [2:0]         mode_in,
    input  logic [CH_W:0]      offset_in,
    input  logic [CH_W-1:0]    threshold_in,
    output logic               hs_out,
    output logic               vs_out,
    output logic [CNT_W-1:0]   hc_visible_out,
    output logic [CNT_W-1:0]   vc_visible_out,
    output logic [3*CH_W-1:0]  pixel_out,
    output logic               frame_start,
    output logic [2:0]         mode_active
);

    localparam int unsigned PW = 3 * CH_W;
    localparam int unsigned BW = 2 + 2 * CNT_W + PW;
    localparam logic [CH_W-1:0] CH_MAX = '1;

    // Frame boundary: vs returns to its inactive level
    logic            vs_q;
    logic            boundary;
    logic [CH_W:0]   offset_act;
    logic [CH_W-1:0] thr_act;

    assign boundary = (vs_in == ~SYNC_ACTIVE) && (vs_q == SYNC_ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q        <= ~SYNC_ACTIVE;
            frame_start <= 1'b0;
            mode_active <= '0;
            offset_act  <= '0;
            thr_act     <= '0;
        end else begin
            vs_q        <= vs_in;
            frame_start <= boundary;
            if (boundary) begin
                mode_active <= mode_in;
                offset_act  <= offset_in;
                thr_act     <= threshold_in;
            end
        end
    end

    // Stage 1: register inputs and the truncated channel average
    logic [CH_W+1:0]  sum;
    logic [CH_W+1:0]  quo;
    logic             s1_hs, s1_vs;
    logic [CNT_W-1:0] s1_hc, s1_vc;
    logic [PW-1:0]    s1_pix;
    logic [CH_W-1:0]  s1_gray;

    assign sum = {2'b00, pixel_in[3*CH_W-1:2*CH_W]} + {2'b00, pixel_in[2*CH_W-1:CH_W]}
               + {2'b00, pixel_in[CH_W-1:0]};
    assign quo = sum / (CH_W+2)'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_hc   <= '0;
            s1_vc   <= '0;
            s1_pix  <= '0;
            s1_gray <= '0;
        end else begin
            s1_hs   <= hs_in;
            s1_vs   <= vs_in;
            s1_hc   <= hc_visible_in;
            s1_vc   <= vc_visible_in;
            s1_pix  <= pixel_in;
            s1_gray <= quo[CH_W-1:0];
        end
    end

    // Channel plus signed offset, clamped to [0, CH_MAX]
    function automatic logic [CH_W-1:0] bright(input logic [CH_W-1:0] c,
                                               input logic [CH_W:0] off);
        logic [CH_W+1:0] t;
        t = {2'b00, c} + {off[CH_W], off};
        if (t[CH_W+1]) return '0;
        else if (t[CH_W]) return CH_MAX;
        else return t[CH_W-1:0];
    endfunction

    // Stage 2: colour operation
    logic [PW-1:0]    s2_d;
    logic             s2_hs, s2_vs;
    logic [CNT_W-1:0] s2_hc, s2_vc;
    logic [PW-1:0]    s2_pix;

    always_comb begin
        s2_d = s1_pix;
        case (mode_active)
            3'd1: s2_d = {s1_gray, s1_gray, s1_gray};
            3'd2: s2_d = ~s1_pix;
            3'd3: s2_d = (s1_gray >= thr_act) ? '1 : '0;
            3'd4: s2_d = {bright(s1_pix[3*CH_W-1:2*CH_W], offset_act),
                          bright(s1_pix[2*CH_W-1:CH_W], offset_act),
                          bright(s1_pix[CH_W-1:0], offset_act)};
            default: s2_d = s1_pix;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
            s2_hc  <= '0;
            s2_vc  <= '0;
            s2_pix <= '0;
        end else begin
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
            s2_hc  <= s1_hc;
            s2_vc  <= s1_vc;
            s2_pix <= s2_d;
        end
    end

    // Stage 3: blank outside the visible area
    logic             s3_hs, s3_vs;
    logic [CNT_W-1:0] s3_hc, s3_vc;
    logic [PW-1:0]    s3_pix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_hs  <= 1'b0;
            s3_vs  <= 1'b0;
            s3_hc  <= '0;
            s3_vc  <= '0;
            s3_pix <= '0;
        end else begin
            s3_hs  <= s2_hs;
            s3_vs  <= s2_vs;
            s3_hc  <= s2_hc;
            s3_vc  <= s2_vc;
            s3_pix <= (s2_hc == '0 || s2_vc == '0) ? '0 : s2_pix;
        end
    end

    logic [BW-1:0] s3_bus;
    logic [BW-1:0] out_bus;

    assign s3_bus = {s3_hs, s3_vs, s3_hc, s3_vc, s3_pix};

    if (EXTRA_DELAY == 0) begin : g_no_delay
        assign out_bus = s3_bus;
    end else begin : g_delay
        logic [BW-1:0] dly_q [EXTRA_DELAY];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < int'(EXTRA_DELAY); i++) dly_q[i] <= '0;
            end else begin
                dly_q[0] <= s3_bus;
                for (int i = 1; i < int'(EXTRA_DELAY); i++) dly_q[i] <= dly_q[i-1];
            end
        end

        assign out_bus = dly_q[EXTRA_DELAY-1];
    end

    assign {hs_out, vs_out, hc_visible_out, vc_visible_out, pixel_out} = out_bus;

endmodule

// File: tb/tb_pixel_proc_pipe.sv
// Scoreboard bench for pixel_proc_pipe: driver pushes model results, monitor pops and compares.
module tb_pixel_proc_pipe;

    localparam int unsigned CH_W  = 4;
    localparam int unsigned CNT_W = 11;
    localparam int unsigned XD    = 2;
    localparam bit          SA    = 1'b0;
    localparam int          L     = 3 + XD;

    logic              clk, rst;
    logic              hs_in, vs_in;
    logic [CNT_W-1:0]  hc_visible_in, vc_visible_in;
    logic [11:0]       pixel_in;
    logic [2:0]        mode_in;
    logic [4:0]        offset_in;
    logic [3:0]        threshold_in;
    logic              hs_out, vs_out, frame_start;
    logic [CNT_W-1:0]  hc_visible_out, vc_visible_out;
    logic [11:0]       pixel_out;
    logic [2:0]        mode_active;

    pixel_proc_pipe #(
        .CH_W(CH_W), .CNT_W(CNT_W), .EXTRA_DELAY(XD), .SYNC_ACTIVE(SA)
    ) dut (
        .clk(clk), .rst(rst), .hs_in(hs_in), .vs_in(vs_in),
        .hc_visible_in(hc_visible_in), .vc_visible_in(vc_visible_in),
        .pixel_in(pixel_in), .mode_in(mode_in), .offset_in(offset_in),
        .threshold_in(threshold_in), .hs_out(hs_out), .vs_out(vs_out),
        .hc_visible_out(hc_visible_out), .vc_visible_out(vc_visible_out),
        .pixel_out(pixel_out), .frame_start(frame_start), .mode_active(mode_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               due;
        logic [11:0]      pix;
        logic             hs, vs;
        logic [CNT_W-1:0] hc, vc;
    } exp_t;

    typedef struct {
        int       due;
        logic     fs;
        logic [2:0] mode;
    } cfg_t;

    exp_t exp_q[$];
    cfg_t cfg_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model state
    logic       m_prev_vs;
    logic [2:0] m_mode;
    logic [4:0] m_off;
    logic [3:0] m_thr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [11:0] ref_pix(input logic [11:0] p, input int hc, input int vc,
                                            input logic [2:0] mode, input logic [4:0] off,
                                            input logic [3:0] thr);
        int ch[3];
        int gray, o, v;
        logic signed [4:0] so;
        logic [11:0] r;
        if (hc == 0 || vc == 0) return 12'h000;
        ch[0] = int'(p[11:8]);
        ch[1] = int'(p[7:4]);
        ch[2] = int'(p[3:0]);
        gray = (ch[0] + ch[1] + ch[2]) / 3;
        so = off;
        o = int'(so);
        for (int i = 0; i < 3; i++) begin
            case (mode)
                3'd1: v = gray;
                3'd2: v = 15 - ch[i];
                3'd3: v = (gray >= int'(thr)) ? 15 : 0;
                3'd4: begin
                    v = ch[i] + o;
                    if (v < 0) v = 0;
                    if (v > 15) v = 15;
                end
                default: v = ch[i];
            endcase
            r[11-4*i -: 4] = 4'(v);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_prev_vs = ~SA;
        m_mode = 3'd0;
        m_off = 5'd0;
        m_thr = 4'd0;
    endtask

    // One pixel per clock; expectations queued as the stimulus goes out
    task automatic drive(input logic hs, input logic vs, input int hc, input int vc,
                         input logic [11:0] pix, input logic [2:0] mode,
                         input logic [4:0] off, input logic [3:0] thr);
        exp_t e;
        cfg_t c;
        logic bnd;
        @(negedge clk);
        hs_in = hs;
        vs_in = vs;
        hc_visible_in = CNT_W'(hc);
        vc_visible_in = CNT_W'(vc);
        pixel_in = pix;
        mode_in = mode;
        offset_in = off;
        threshold_in = thr;
        bnd = (vs == ~SA) && (m_prev_vs == SA);
        if (bnd) begin
            m_mode = mode;
            m_off = off;
            m_thr = thr;
        end
        m_prev_vs = vs;
        e.due = cyc + L;
        e.pix = ref_pix(pix, hc, vc, m_mode, m_off, m_thr);
        e.hs = hs;
        e.vs = vs;
        e.hc = CNT_W'(hc);
        e.vc = CNT_W'(vc);
        exp_q.push_back(e);
        c.due = cyc + 1;
        c.fs = bnd;
        c.mode = m_mode;
        cfg_q.push_back(c);
    endtask

    task automatic new_frame(input logic [2:0] mode, input logic [4:0] off, input logic [3:0] thr);
        drive(1'b1, SA, 0, 0, 12'h000, mode, off, thr);
        drive(1'b1, ~SA, 0, 0, 12'h000, mode, off, thr);
    endtask

    // Monitor: compare whatever is due just after each active edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("due_cycle", 32'(cyc), 32'(e.due));
                check("pixel_out", 32'(pixel_out), 32'(e.pix));
                check("hs_out", 32'(hs_out), 32'(e.hs));
                check("vs_out", 32'(vs_out), 32'(e.vs));
                check("hc_out", 32'(hc_visible_out), 32'(e.hc));
                check("vc_out", 32'(vc_visible_out), 32'(e.vc));
            end
            while (cfg_q.size() > 0 && cfg_q[0].due <= cyc) begin
                cfg_t c;
                c = cfg_q.pop_front();
                check("frame_start", 32'(frame_start), 32'(c.fs));
                check("mode_active", 32'(mode_active), 32'(c.mode));
            end
        end
    end

    initial begin
        rst = 1'b1;
        hs_in = 1'b1;
        vs_in = ~SA;
        hc_visible_in = '0;
        vc_visible_in = '0;
        pixel_in = '0;
        mode_in = '0;
        offset_in = '0;
        threshold_in = '0;
        model_reset();
        #12;
        check("reset_pixel", 32'(pixel_out), 32'h0);
        check("reset_mode", 32'(mode_active), 32'h0);
        check("reset_fs", 32'(frame_start), 32'h0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Latency and alignment, bypass after reset
        drive(1'b1, ~SA, 3, 3, 12'h111, 3'd0, 5'd0, 4'd0);
        drive(1'b0, ~SA, 5, 7, 12'hA5C, 3'd0, 5'd0, 4'd0);
        drive(1'b1, ~SA, 6, 7, 12'h3C5, 3'd0, 5'd0, 4'd0);

        // Mode request mid-frame is ignored until the vs inactive edge
        for (int i = 0; i < 4; i++) drive(1'b1, ~SA, 10, 10, 12'h18F, 3'd2, 5'd0, 4'd0);
        drive(1'b1, SA, 10, 10, 12'h18F, 3'd2, 5'd0, 4'd0);
        for (int i = 0; i < 4; i++) drive(1'b1, ~SA, 10, 10, 12'h18F, 3'd2, 5'd0, 4'd0);

        // Gray and threshold
        new_frame(3'd1, 5'd0, 4'd0);
        drive(1'b1, ~SA, 1, 1, 12'hF30, 3'd1, 5'd0, 4'd0);
        new_frame(3'd3, 5'd0, 4'd6);
        drive(1'b1, ~SA, 1, 1, 12'hF30, 3'd3, 5'd0, 4'd6);
        new_frame(3'd3, 5'd0, 4'd7);
        drive(1'b1, ~SA, 1, 1, 12'hF30, 3'd3, 5'd0, 4'd7);

        // Saturating brightness, both directions
        new_frame(3'd4, 5'd5, 4'd0);
        drive(1'b1, ~SA, 2, 2, 12'hC20, 3'd4, 5'd5, 4'd0);
        new_frame(3'd4, 5'h1D, 4'd0);
        drive(1'b1, ~SA, 2, 2, 12'h2A1, 3'd4, 5'h1D, 4'd0);

        // Blanking in non-bypass modes
        drive(1'b1, ~SA, 0, 9, 12'hFFF, 3'd4, 5'h1D, 4'd0);
        drive(1'b1, ~SA, 9, 0, 12'hFFF, 3'd4, 5'h1D, 4'd0);
        new_frame(3'd2, 5'd0, 4'd0);
        drive(1'b1, ~SA, 0, 4, 12'hFFF, 3'd2, 5'd0, 4'd0);

        // Randomized traffic with occasional frame boundaries and blanking
        for (int i = 0; i < 400; i++) begin
            logic vs_r;
            int hc_r, vc_r;
            vs_r = ($urandom_range(0, 19) == 0) ? SA : ~SA;
            hc_r = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 639));
            vc_r = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 479));
            drive(1'($urandom), vs_r, hc_r, vc_r, 12'($urandom), 3'($urandom),
                  5'($urandom), 4'($urandom));
        end

        // Asynchronous reset during invert traffic
        new_frame(3'd2, 5'd0, 4'd0);
        for (int i = 0; i < 8; i++) drive(1'b1, ~SA, 20 + i, 30, 12'($urandom), 3'd2, 5'd0, 4'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_pixel", 32'(pixel_out), 32'h0);
        check("rst_hc", 32'(hc_visible_out), 32'h0);
        check("rst_vc", 32'(vc_visible_out), 32'h0);
        check("rst_sync", 32'({hs_out, vs_out}), 32'h0);
        check("rst_mode", 32'(mode_active), 32'h0);
        check("rst_fs", 32'(frame_start), 32'h0);
        exp_q.delete();
        cfg_q.delete();
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        drive(1'b1, ~SA, 4, 4, 12'h123, 3'd2, 5'd0, 4'd0);
        for (int i = 0; i < 6; i++) drive(1'b1, ~SA, 4, 4, 12'(i * 37), 3'd2, 5'd0, 4'd0);

        // Drain; anything still queued after the bound is a miss
        for (int i = 0; i < L + 4 && (exp_q.size() > 0 || cfg_q.size() > 0); i++)
            @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size() + cfg_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
